// File: rtl/tile_scroll_engine.sv
// tile_scroll_engine: scrolls a latched one-hot song, judges key presses on
// the hit row, keeps score/misses/win-lose state. Optional macro TILE_LIVES_EN.
// Ports: clk, resetn, start, song, key_pressed -> window, score, lives_left,
// playing, won, lost, hit_pulse, miss_pulse.
module tile_scroll_engine #(
  parameter int ROWS     = 31,
  parameter int VISIBLE  = 4,
  parameter int TICK_DIV = 25_000_000,
  parameter int SCORE_W  = 8,
  parameter int LIVES    = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [4*ROWS-1:0]      song,
  input  logic [3:0]             key_pressed,
  output logic [4*VISIBLE-1:0]   window,
  output logic [SCORE_W-1:0]     score,
  output logic [1:0]             lives_left,
  output logic                   playing,
  output logic                   won,
  output logic                   lost,
  output logic                   hit_pulse,
  output logic                   miss_pulse
);

  localparam int SW = 4*ROWS;
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(ROWS+1);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV-1);
  localparam logic [RW-1:0] ROWS_INIT = RW'(ROWS);
  localparam logic [SW-1:0] HIT_MASK  = {4'hF, {(SW-4){1'b0}}};

  typedef enum logic [1:0] {IDLE, PLAY, WON, LOST} state_t;

  state_t             state, state_nxt;
  logic [SW-1:0]      sreg;
  logic [CW-1:0]      tick_cnt;
  logic [RW-1:0]      rows_left;
  logic [3:0]         key_q;
  logic [3:0]         hit_row;
  logic [3:0]         rise;
  logic               in_play;
  logic               judge;
  logic               hit;
  logic               wrong;
  logic               tick;
  logic               miss;
  logic               fatal;

  assign hit_row = sreg[SW-1 -: 4];
  assign rise    = key_pressed & ~key_q;
  assign in_play = (state == PLAY);
  assign judge   = in_play && (|rise) && (|hit_row);
  assign hit     = judge && (rise == hit_row);
  assign wrong   = judge && !hit;
  assign tick    = in_play && (tick_cnt == TICK_LAST);
  // a wrong key on the tick cycle is the same miss as the tick miss
  assign miss    = wrong || (tick && (|hit_row) && !hit);

`ifdef TILE_LIVES_EN
  logic [1:0] lives;
  assign fatal      = miss && (lives <= 2'd1);
  assign lives_left = lives;
`else
  assign fatal      = miss;
  assign lives_left = 2'b00;
`endif

  assign window  = sreg[SW-1 -: 4*VISIBLE];
  assign playing = (state == PLAY);
  assign won     = (state == WON);
  assign lost    = (state == LOST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = PLAY;
      PLAY: begin
        if (start)                 state_nxt = PLAY;
        else if (fatal)            state_nxt = LOST;
        else if (rows_left == '0)  state_nxt = WON;
      end
      WON:  if (start) state_nxt = PLAY;
      LOST: if (start) state_nxt = PLAY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sreg       <= '0;
      tick_cnt   <= '0;
      rows_left  <= '0;
      score      <= '0;
      key_q      <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
`ifdef TILE_LIVES_EN
      lives      <= 2'd0;
`endif
    end else begin
      key_q      <= key_pressed;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (start) begin
        sreg      <= song;
        tick_cnt  <= '0;
        rows_left <= ROWS_INIT;
        score     <= '0;
`ifdef TILE_LIVES_EN
        lives     <= 2'(LIVES);
`endif
      end else if (in_play) begin
        hit_pulse  <= hit;
        miss_pulse <= miss;
        if (hit && (score != '1)) score <= score + SCORE_W'(1);
`ifdef TILE_LIVES_EN
        if (miss && (lives != 2'd0)) lives <= lives - 2'd1;
`endif
        tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
        // a fatal miss freezes the playfield as it was
        if (!fatal) begin
          if (tick) begin
            sreg <= sreg << 4;
            if (rows_left != '0) rows_left <= rows_left - RW'(1);
          end else if (hit || wrong) begin
            sreg <= sreg & ~HIT_MASK;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_scroll_engine.sv
// tb_tile_scroll_engine: directed vectors and hand sequences for
// tile_scroll_engine with TICK_DIV=4, ROWS=31.
module tb_tile_scroll_engine;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [123:0] song;
  logic [3:0]   key_pressed;
  logic [15:0]  window;
  logic [7:0]   score;
  logic [1:0]   lives_left;
  logic         playing, won, lost, hit_pulse, miss_pulse;

  int total = 0;
  int bad   = 0;

  tile_scroll_engine #(
    .ROWS(31), .VISIBLE(4), .TICK_DIV(4), .SCORE_W(8), .LIVES(3)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .song(song),
    .key_pressed(key_pressed), .window(window), .score(score),
    .lives_left(lives_left), .playing(playing), .won(won), .lost(lost),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  always #5 clk = ~clk;

`ifdef TILE_LIVES_EN
  localparam bit LIVES_ON = 1'b1;
`else
  localparam bit LIVES_ON = 1'b0;
`endif

  typedef struct {
    logic [3:0]  row0;
    logic [3:0]  key;
    int          p;
    logic        hit;
    logic        miss;
    logic [15:0] win_off;
    logic [15:0] win_on;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_game(input logic [123:0] s);
    song  = s;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [123:0] mk_song(input logic [3:0] r0);
    return {r0, 4'h1, 4'h8, 4'h4, 108'b0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [123:0] s;
    logic [15:0]  wexp;
    int hits, misses, n;

    vecs[0] = '{4'h2, 4'h2, 0, 1'b1, 1'b0, 16'h0184, 16'h0184};
    vecs[1] = '{4'h2, 4'h4, 0, 1'b0, 1'b1, 16'h2184, 16'h0184};
    vecs[2] = '{4'h2, 4'h2, 3, 1'b1, 1'b0, 16'h1840, 16'h1840};
    vecs[3] = '{4'h0, 4'h4, 1, 1'b0, 1'b0, 16'h0184, 16'h0184};
    vecs[4] = '{4'h8, 4'hA, 0, 1'b0, 1'b1, 16'h8184, 16'h0184};
    vecs[5] = '{4'h4, 4'h4, 2, 1'b1, 1'b0, 16'h0184, 16'h0184};
    vecs[6] = '{4'h1, 4'h2, 3, 1'b0, 1'b1, 16'h1184, 16'h1840};

    resetn = 1'b0;
    start = 1'b0;
    song = '0;
    key_pressed = 4'h0;
    step();
    step();
    chk("rst_flags", {27'b0, playing, won, lost, hit_pulse, miss_pulse}, 0);
    chk("rst_window", {16'b0, window}, 0);
    chk("rst_score", {24'b0, score}, 0);
    chk("rst_lives", {30'b0, lives_left}, 0);
    resetn = 1'b1;
    step();

    // mid-game async reset
    begin_game(mk_song(4'h2));
    chk("start_window", {16'b0, window}, 32'h2184);
    chk("start_playing", {31'b0, playing}, 1);
    chk("start_lives", {30'b0, lives_left}, LIVES_ON ? 3 : 0);
    key_pressed = 4'h2;
    step();
    key_pressed = 4'h0;
    chk("pre_rst_score", {24'b0, score}, 1);
    step();
    #2 resetn = 1'b0;
    #1;
    chk("async_flags", {27'b0, playing, won, lost, hit_pulse, miss_pulse}, 0);
    chk("async_window", {16'b0, window}, 0);
    chk("async_score", {24'b0, score}, 0);
    #1 resetn = 1'b1;
    step();
    s = {4'h4, 4'h2, 4'h1, 4'h8, 108'b0};
    begin_game(s);
    chk("restart_window", {16'b0, window}, {16'b0, s[123:108]});
    chk("restart_playing", {31'b0, playing}, 1);

    // single-press judging vectors
    for (int i = 0; i < 7; i++) begin
      key_pressed = 4'h0;
      step();
      begin_game(mk_song(vecs[i].row0));
      repeat (vecs[i].p) step();
      key_pressed = vecs[i].key;
      step();
      key_pressed = 4'h0;
      wexp = LIVES_ON ? vecs[i].win_on : vecs[i].win_off;
      chk($sformatf("v%0d_hit", i), {31'b0, hit_pulse}, {31'b0, vecs[i].hit});
      chk($sformatf("v%0d_miss", i), {31'b0, miss_pulse}, {31'b0, vecs[i].miss});
      chk($sformatf("v%0d_score", i), {24'b0, score}, {31'b0, vecs[i].hit});
      chk($sformatf("v%0d_window", i), {16'b0, window}, {16'b0, wexp});
      chk($sformatf("v%0d_lost", i), {31'b0, lost},
          {31'b0, vecs[i].miss & ~LIVES_ON});
      chk($sformatf("v%0d_lives", i), {30'b0, lives_left},
          LIVES_ON ? 3 - int'(vecs[i].miss) : 0);
    end

    // no key: miss lands on the 4th clock
    key_pressed = 4'h0;
    step();
    begin_game(mk_song(4'h2));
    misses = 0;
    repeat (3) begin
      step();
      misses += int'(miss_pulse);
    end
    chk("tick_early_miss", misses, 0);
    step();
    chk("tick_miss", {31'b0, miss_pulse}, 1);
    chk("tick_lost", {31'b0, lost}, {31'b0, ~LIVES_ON});
    chk("tick_window", {16'b0, window}, LIVES_ON ? 32'h1840 : 32'h2184);

    // key held across two rows: only the first edge is judged
    key_pressed = 4'h0;
    step();
    begin_game({4'h2, 4'h2, 116'b0});
    key_pressed = 4'h2;
    hits = 0;
    misses = 0;
    for (int c = 0; c < 7; c++) begin
      step();
      hits += int'(hit_pulse);
      misses += int'(miss_pulse);
    end
    chk("held_hits", hits, 1);
    chk("held_no_miss", misses, 0);
    step();
    chk("held_miss", {31'b0, miss_pulse}, 1);
    chk("held_score", {24'b0, score}, 1);
    key_pressed = 4'h0;

    // full song, every row hit on its tick cycle
    step();
    s = '0;
    for (int r = 0; r < 31; r++) s[123-4*r -: 4] = 4'(1 << (r % 4));
    begin_game(s);
    hits = 0;
    misses = 0;
    for (int r = 0; r < 31; r++) begin
      repeat (3) step();
      key_pressed = 4'(1 << (r % 4));
      step();
      key_pressed = 4'h0;
      hits += int'(hit_pulse);
      misses += int'(miss_pulse);
    end
    chk("win_hits", hits, 31);
    chk("win_misses", misses, 0);
    chk("win_not_yet", {31'b0, won}, 0);
    step();
    chk("win_won", {31'b0, won}, 1);
    chk("win_score", {24'b0, score}, 31);
    chk("win_playing", {31'b0, playing}, 0);

    // misses until loss, then restart
    step();
    begin_game({4'h2, 4'h2, 4'h2, 4'h2, 108'b0});
    misses = 0;
    n = 0;
    while (!lost && n < 40) begin
      step();
      misses += int'(miss_pulse);
      n++;
    end
    chk("lose_reached", {31'b0, lost}, 1);
    chk("lose_misses", misses, LIVES_ON ? 3 : 1);
    chk("lose_cycles", n, LIVES_ON ? 12 : 4);
    chk("lose_lives", {30'b0, lives_left}, 0);
    begin_game(mk_song(4'h1));
    chk("again_playing", {31'b0, playing}, 1);
    chk("again_score", {24'b0, score}, 0);
    chk("again_lives", {30'b0, lives_left}, LIVES_ON ? 3 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
